// File: rtl/vt_seq_pkg.sv
// Shared definitions for the serial sequence-detector path.
package vt_seq_pkg;

  // Serializer FSM: waiting for a word, or driving bits of one.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_st_e;

  // Pattern the downstream detector fires on (first bit received on the left).
  localparam logic [5:0] SEQ_PATTERN = 6'b100110;

  // Default word width for the serializer.
  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/vt_byte_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one registered bit
// per clock out, with a one-word holding register so back-to-back words
// stream without a gap on o_SI.
module vt_byte_serializer
  import vt_seq_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_SI,
  output logic              o_bit_valid,
  output logic              o_busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  seq_st_e           st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              si_q, si_d;
  logic              bv_q, bv_d;

  logic accept;
  logic load_evt;

  // Ready depends only on the holding register, never on i_valid.
  assign o_ready  = !hold_full_q;
  assign accept   = i_valid && !hold_full_q;
  // Shifter wants a new word when idle or while its last bit is on the line.
  assign load_evt = (st_q == ST_IDLE) || ((st_q == ST_SHIFT) && (cnt_q == LAST_CNT));

  // Next-state: load from hold first, else bypass the accepted word,
  // else shift; words arriving while the shifter is busy park in hold.
  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load_evt) begin
      cnt_d = '0;
      if (hold_full_q) begin
        // accept is impossible here since o_ready is low while hold is full
        sh_d        = hold_q;
        hold_full_d = 1'b0;
        st_d        = ST_SHIFT;
      end else if (accept) begin
        sh_d = i_data;
        st_d = ST_SHIFT;
      end else begin
        st_d = ST_IDLE;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      sh_d  = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};
      if (accept) begin
        hold_d      = i_data;
        hold_full_d = 1'b1;
      end
    end
  end

  // Output bit comes from the new shifter contents so the first bit of a
  // freshly loaded word appears right after the accepting edge.
  always_comb begin
    bv_d = (st_d == ST_SHIFT);
    si_d = IDLE_BIT;
    if (st_d == ST_SHIFT) si_d = MSB_FIRST ? sh_d[DATA_W-1] : sh_d[0];
  end

  // State and output registers; reset drops in-flight and held words.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q        <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      si_q        <= IDLE_BIT;
      bv_q        <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      si_q        <= si_d;
      bv_q        <= bv_d;
    end
  end

  assign o_SI        = si_q;
  assign o_bit_valid = bv_q;
  assign o_busy      = (st_q == ST_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_vt_byte_serializer.sv
// Directed bench for vt_byte_serializer: an MSB-first instance and an
// LSB-first instance share clock and reset.
module tb_vt_byte_serializer;
  import vt_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       ready0, si0, bv0, busy0;
  logic       ready1, si1, bv1, busy1;

  int n_chk  = 0;
  int n_fail = 0;
  logic q0[$];

  always #5 clk = ~clk;

  vt_byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_data(data0), .i_valid(valid0),
    .o_ready(ready0), .o_SI(si0), .o_bit_valid(bv0), .o_busy(busy0));

  vt_byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1),
    .o_ready(ready1), .o_SI(si1), .o_bit_valid(bv1), .o_busy(busy1));

  // Collect valid bits of the MSB-first instance away from the rising edge.
  always @(negedge clk) if (bv0) q0.push_back(si0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] val(input int j);
    return 8'(j * 29 + 3);
  endfunction

  initial begin
    logic [7:0]  w8;
    logic [15:0] w16;
    logic [31:0] w32;
    logic [5:0]  win;
    int          nbv;
    bit          done;

    // Reset state, before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_state0", {si0, bv0, ready0, busy0}, 4'b0010);
    chk("rst_state1", {si1, bv1, ready1, busy1}, 4'b0010);
    step(); step();
    rst = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", {si0, bv0, ready0, busy0}, 4'b0010);
    end

    // Single word 9A, MSB first, with detector window model
    w8 = 8'h9A; win = '0;
    data0 = w8; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s2_bit", {bv0, si0}, {1'b1, w8[7-i]});
      win = {win[4:0], si0};
      chk("s2_det", 32'(win == SEQ_PATTERN), 32'(i == 5));
      step();
    end
    chk("s2_end", {si0, bv0, busy0}, 3'b000);

    // Back-to-back 9A, 66
    w16 = 16'h9A66;
    data0 = 8'h9A; valid0 = 1'b1;
    step();
    data0 = 8'h66;
    chk("s3_bit", {bv0, si0}, {1'b1, w16[15]});
    chk("s3_rdy0", ready0, 1'b1);
    step();
    valid0 = 1'b0; data0 = 8'h00;
    for (int i = 1; i < 16; i++) begin
      chk("s3_bit", {bv0, si0}, {1'b1, w16[15-i]});
      if (i >= 1 && i <= 6) chk("s3_rdy_lo", ready0, 1'b0);
      if (i == 8) chk("s3_rdy_hi", ready0, 1'b1);
      step();
    end
    chk("s3_end", {si0, bv0, busy0, ready0}, 4'b0001);

    // LSB first, 59 -> 1,0,0,1,1,0,1,0
    w8 = 8'b1001_1010;
    data1 = 8'h59; valid1 = 1'b1;
    step();
    valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s4_bit", {bv1, si1}, {1'b1, w8[7-i]});
      step();
    end
    chk("s4_end", {si1, bv1, busy1}, 3'b000);

    // i_valid held high with changing data; accepts at edges 0,1,9,17
    step();
    q0.delete();
    nbv = 0; done = 0;
    for (int j = 0; j < 18; j++) begin
      data0 = val(j); valid0 = 1'b1;
      step();
      if (bv0) nbv++;
    end
    valid0 = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (!bv0) done = 1;
      else begin
        step();
        if (bv0) nbv++;
      end
    end
    chk("s5_drained", 32'(done), 32'd1);
    chk("s5_gapless", nbv, 32'd32);
    chk("s5_nbits", q0.size(), 32'd32);
    w32 = '0;
    for (int i = 0; i < 32 && i < q0.size(); i++) w32 = {w32[30:0], q0[i]};
    chk("s5_stream", w32, {val(0), val(1), val(9), val(17)});

    // Reset at bit 3 of a word with hold full
    step();
    w8 = 8'hA5;
    data0 = w8; valid0 = 1'b1;
    step();
    data0 = 8'h3C;
    step();
    valid0 = 1'b0;
    step(); step();
    chk("s6_bit3", {bv0, si0}, {1'b1, w8[4]});
    chk("s6_full", {busy0, ready0}, 2'b10);
    rst = 1'b1;
    #1;
    chk("s6_async", {si0, bv0, ready0, busy0}, 4'b0010);
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("s6_discard", {bv0, busy0}, 2'b00);
    q0.delete();
    w8 = 8'hF0;
    data0 = w8; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s6_bit", {bv0, si0}, {1'b1, w8[7-i]});
      step();
    end
    step(); step();
    chk("s6_end", {si0, bv0, busy0}, 3'b000);
    chk("s6_nbits", q0.size(), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
